// File: rtl/sram_bist_ctrl_if.sv
// SRAM write/read port bundle between the BIST controller (master) and the
// synchronous dual-port SRAM (slave).
interface sram_bist_ctrl_if #(
   parameter int data_width    = 8,
   parameter int address_width = 4
);
   logic                     wr_en;
   logic [address_width-1:0] wr_addr;
   logic [data_width-1:0]    data_in;
   logic                     rd_en;
   logic [address_width-1:0] rd_addr;
   logic [data_width-1:0]    data_out_port;

   modport master (
      output wr_en, wr_addr, data_in, rd_en, rd_addr,
      input  data_out_port
   );

   modport slave (
      input  wr_en, wr_addr, data_in, rd_en, rd_addr,
      output data_out_port
   );
endinterface

// File: rtl/sram_bist_ctrl.sv
// Two-pass SRAM BIST: write pattern^addr, read-compare, then repeat with the
// inverted pattern; reports pass, first failing address and a saturating count.
module sram_bist_ctrl #(
   parameter int                    data_width    = 8,
   parameter int                    RAM_size      = 16,
   parameter int                    address_width = 4,
   parameter logic [data_width-1:0] pattern       = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   sram_bist_ctrl_if.master         bus,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [address_width-1:0] fail_addr,
   output logic [7:0]               fail_count
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [address_width-1:0] LAST_ADDR = address_width'(RAM_size - 1);
   localparam logic [address_width-1:0] ZERO_ADDR = address_width'(32'd0);
   localparam logic [address_width-1:0] ONE_ADDR  = address_width'(32'd1);
   localparam logic [data_width-1:0]    ZERO_DATA = data_width'(32'd0);

   state_t                   state_r, state_s;
   logic                     p_r, p_s;
   logic [address_width-1:0] a_r, a_s;
   logic                     clear_s;

   logic                     wr_en_r, wr_en_s;
   logic [address_width-1:0] wr_addr_r, wr_addr_s;
   logic [data_width-1:0]    data_in_r, data_in_s;
   logic                     rd_en_r, rd_en_s;
   logic [address_width-1:0] rd_addr_r, rd_addr_s;
   logic                     busy_r, busy_s;
   logic                     done_r, done_s;

   logic                     cmp_valid_r;
   logic [address_width-1:0] cmp_addr_r;
   logic [data_width-1:0]    cmp_exp_r;
   logic                     miscompare_s;

   logic                     pass_r;
   logic [address_width-1:0] fail_addr_r;
   logic [7:0]               fail_count_r;

   function automatic logic [data_width-1:0] expected(
      input logic                     pass_sel,
      input logic [address_width-1:0] addr
   );
      logic [data_width-1:0] base;
      base = pattern ^ data_width'(addr);
      return pass_sel ? ~base : base;
   endfunction

   // Next-state, counters and the next value of every registered bus/status output.
   always_comb begin
      state_s = state_r;
      p_s     = p_r;
      a_s     = a_r;
      clear_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s = ST_WRITE;
               p_s     = 1'b0;
               a_s     = ZERO_ADDR;
               clear_s = 1'b1;
            end else begin
               state_s = state_r;
            end
         end
         ST_WRITE: begin
            if (a_r == LAST_ADDR) begin
               state_s = ST_READ;
               a_s     = ZERO_ADDR;
            end else begin
               a_s = a_r + ONE_ADDR;
            end
         end
         ST_READ: begin
            if (a_r == LAST_ADDR) begin
               state_s = ST_FLUSH;
               a_s     = ZERO_ADDR;
            end else begin
               a_s = a_r + ONE_ADDR;
            end
         end
         ST_FLUSH: begin
            if (!p_r) begin
               p_s     = 1'b1;
               state_s = ST_WRITE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            p_s     = 1'b0;
            a_s     = ZERO_ADDR;
         end
      endcase

      // Outputs follow the state being entered so they appear registered with it.
      wr_en_s   = (state_s == ST_WRITE);
      wr_addr_s = wr_en_s ? a_s : ZERO_ADDR;
      data_in_s = wr_en_s ? expected(p_s, a_s) : ZERO_DATA;
      rd_en_s   = (state_s == ST_READ);
      rd_addr_s = rd_en_s ? a_s : ZERO_ADDR;
      busy_s    = (state_s == ST_WRITE) || (state_s == ST_READ) || (state_s == ST_FLUSH);
      done_s    = (state_s == ST_DONE);
   end

   // State register, address counter and registered SRAM/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         p_r       <= 1'b0;
         a_r       <= ZERO_ADDR;
         wr_en_r   <= 1'b0;
         wr_addr_r <= ZERO_ADDR;
         data_in_r <= ZERO_DATA;
         rd_en_r   <= 1'b0;
         rd_addr_r <= ZERO_ADDR;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         p_r       <= p_s;
         a_r       <= a_s;
         wr_en_r   <= wr_en_s;
         wr_addr_r <= wr_addr_s;
         data_in_r <= data_in_s;
         rd_en_r   <= rd_en_s;
         rd_addr_r <= rd_addr_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   // Delay the issued read's address and expected data to meet the SRAM read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_valid_r <= 1'b0;
         cmp_addr_r  <= ZERO_ADDR;
         cmp_exp_r   <= ZERO_DATA;
      end else begin
         cmp_valid_r <= rd_en_r;
         cmp_addr_r  <= rd_addr_r;
         cmp_exp_r   <= expected(p_r, rd_addr_r);
      end
   end

   // Miscompare detect on the aligned read data.
   always_comb begin
      miscompare_s = cmp_valid_r & (bus.data_out_port != cmp_exp_r);
   end

   // Result registers; pass_r still high means no earlier miscompare this run.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_r       <= 1'b0;
         fail_addr_r  <= ZERO_ADDR;
         fail_count_r <= 8'd0;
      end else if (clear_s) begin
         pass_r       <= 1'b1;
         fail_addr_r  <= ZERO_ADDR;
         fail_count_r <= 8'd0;
      end else if (miscompare_s) begin
         pass_r       <= 1'b0;
         fail_addr_r  <= pass_r ? cmp_addr_r : fail_addr_r;
         fail_count_r <= (fail_count_r == 8'd255) ? fail_count_r : fail_count_r + 8'd1;
      end else begin
         pass_r       <= pass_r;
         fail_addr_r  <= fail_addr_r;
         fail_count_r <= fail_count_r;
      end
   end

   assign bus.wr_en   = wr_en_r;
   assign bus.wr_addr = wr_addr_r;
   assign bus.data_in = data_in_r;
   assign bus.rd_en   = rd_en_r;
   assign bus.rd_addr = rd_addr_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign pass        = pass_r;
   assign fail_addr   = fail_addr_r;
   assign fail_count  = fail_count_r;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: SRAM models with fault injection, a cycle-indexed
// behavioural model of the run, and directed runs with literal expectations.
module tb_sram_bist_ctrl;

   localparam int RUN   = 66;
   localparam int RUN_B = 2 * (2 * 256 + 1);

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic start2;
   int   fault_mode;

   logic       busy, done, pass;
   logic [3:0] fail_addr;
   logic [7:0] fail_count;
   logic       busy2, done2, pass2;
   logic [7:0] fail_addr2;
   logic [7:0] fail_count2;

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   int m_k = -1;
   int m_mode = 0;

   always #5 clk = ~clk;

   sram_bist_ctrl_if #(.data_width(8), .address_width(4)) bus_a ();
   sram_bist_ctrl_if #(.data_width(8), .address_width(8)) bus_b ();

   sram_bist_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus_a),
      .busy(busy), .done(done), .pass(pass),
      .fail_addr(fail_addr), .fail_count(fail_count)
   );

   sram_bist_ctrl #(.data_width(8), .RAM_size(256), .address_width(8), .pattern(8'hA5)) dut_b (
      .clk(clk), .rst(rst), .start(start2), .bus(bus_b),
      .busy(busy2), .done(done2), .pass(pass2),
      .fail_addr(fail_addr2), .fail_count(fail_count2)
   );

   function automatic logic [7:0] apply_fault(input logic [7:0] d, input int a, input int mode);
      logic [7:0] r;
      r = d;
      if (mode == 1 && a == 5) r[0] = 1'b0;
      else if (mode == 2) r = d ^ 8'h01;
      return r;
   endfunction

   function automatic logic [7:0] exp_val(input int h, input int a);
      logic [7:0] v;
      v = 8'hA5 ^ 8'(a);
      return (h == 1) ? ~v : v;
   endfunction

   // Whole-run outcome: every address read once per pass, pass 0 first.
   task automatic model_result(input int mode, output logic p, output int fa, output int fc);
      int cnt;
      logic [7:0] e;
      cnt = 0;
      p = 1'b1;
      fa = 0;
      for (int h = 0; h < 2; h++) begin
         for (int a = 0; a < 16; a++) begin
            e = exp_val(h, a);
            if (apply_fault(e, a, mode) != e) begin
               if (p) fa = a;
               p = 1'b0;
               cnt++;
            end
         end
      end
      fc = (cnt > 255) ? 255 : cnt;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM A: one-cycle read latency with the selected fault on the read path.
   logic [7:0] mem_a [16];
   always @(posedge clk) begin
      if (bus_a.wr_en) mem_a[bus_a.wr_addr] <= bus_a.data_in;
      if (bus_a.rd_en) bus_a.data_out_port <= apply_fault(mem_a[bus_a.rd_addr], int'(bus_a.rd_addr), fault_mode);
   end

   // SRAM B: every read corrupted.
   logic [7:0] mem_b [256];
   always @(posedge clk) begin
      if (bus_b.wr_en) mem_b[bus_b.wr_addr] <= bus_b.data_in;
      if (bus_b.rd_en) bus_b.data_out_port <= mem_b[bus_b.rd_addr] ^ 8'h01;
   end

   // Model: cycles elapsed since the accepted start, -1 when idle.
   always @(posedge clk) begin
      if (rst) begin
         m_k <= -1;
      end else if ((m_k == -1 || m_k == RUN) && start) begin
         m_k <= 0;
         m_mode <= fault_mode;
      end else if (m_k >= 0 && m_k < RUN) begin
         m_k <= m_k + 1;
      end
   end

   // Per-cycle compare of DUT A against the model.
   always @(negedge clk) begin
      int h, j, fa, fc;
      logic ex_busy, ex_wr, ex_rd, mp;
      if (chk_en) begin
         ex_busy = (m_k >= 0 && m_k < RUN);
         h = (m_k >= 0) ? m_k / 33 : 0;
         j = (m_k >= 0) ? m_k % 33 : 0;
         ex_wr = ex_busy && j < 16;
         ex_rd = ex_busy && j >= 16 && j < 32;
         check("busy", busy, ex_busy);
         check("done", done, m_k == RUN);
         check("wr_en", bus_a.wr_en, ex_wr);
         check("rd_en", bus_a.rd_en, ex_rd);
         if (ex_wr) begin
            check("wr_addr", bus_a.wr_addr, j);
            check("data_in", bus_a.data_in, exp_val(h, j));
         end
         if (ex_rd) check("rd_addr", bus_a.rd_addr, j - 16);
         if (m_k == -1) begin
            check("idle_pass", pass, 0);
            check("idle_fail_addr", fail_addr, 0);
            check("idle_fail_count", fail_count, 0);
         end
         if (m_k == 0) begin
            check("clr_pass", pass, 1);
            check("clr_fail_addr", fail_addr, 0);
            check("clr_fail_count", fail_count, 0);
         end
         if (m_k == RUN) begin
            model_result(m_mode, mp, fa, fc);
            check("res_pass", pass, mp);
            check("res_fail_addr", fail_addr, fa);
            check("res_fail_count", fail_count, fc);
         end
      end
   end

   int   lit_n    [6] = '{0, 1, 2, 3, 33, 38};
   int   lit_addr [6] = '{0, 1, 2, 3, 0, 5};
   logic [7:0] lit_dat [6] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'h5A, 8'h5F};

   // Start a run from a negedge; returns the number of busy cycles before done.
   task automatic do_run(input int mode, input int restart_at, input logic lit_writes, output int busy_cycles);
      fault_mode = mode;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_cycles = 0;
      for (int n = 0; n < 300; n++) begin
         if (n == 0) begin
            check("start_busy", busy, 1);
            check("start_done", done, 0);
            check("start_fail_count", fail_count, 0);
         end
         for (int q = 0; q < 6; q++) begin
            if (lit_writes && n == lit_n[q]) begin
               check("lit_wr_en", bus_a.wr_en, 1);
               check("lit_wr_addr", bus_a.wr_addr, lit_addr[q]);
               check("lit_data_in", bus_a.data_in, lit_dat[q]);
            end
         end
         if (busy) busy_cycles++;
         start = (n == restart_at) ? 1'b1 : 1'b0;
         if (done) break;
         @(negedge clk);
      end
      start = 1'b0;
      check("done_reached", done, 1);
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      fault_mode = 0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_fail_count", fail_count, 0);

      do_run(0, -1, 1'b1, cyc);
      check("clean_cycles", cyc, 66);
      check("clean_pass", pass, 1);
      check("clean_fail_count", fail_count, 0);
      check("clean_fail_addr", fail_addr, 0);

      do_run(1, -1, 1'b0, cyc);
      check("stuck_pass", pass, 0);
      check("stuck_fail_addr", fail_addr, 5);
      check("stuck_fail_count", fail_count, 1);

      do_run(2, -1, 1'b0, cyc);
      check("all_pass", pass, 0);
      check("all_fail_addr", fail_addr, 0);
      check("all_fail_count", fail_count, 32);

      do_run(0, 10, 1'b0, cyc);
      check("restart_ignored_cycles", cyc, 66);
      check("restart_pass", pass, 1);

      fault_mode = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_en", bus_a.wr_en, 0);
      check("rst_rd_en", bus_a.rd_en, 0);
      check("rst_pass", pass, 0);
      check("rst_fail_count", fail_count, 0);
      do_run(0, -1, 1'b0, cyc);
      check("after_rst_cycles", cyc, 66);
      check("after_rst_pass", pass, 1);

      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      cyc = 0;
      for (int n = 0; n < 1200; n++) begin
         if (busy2) cyc++;
         if (done2) break;
         @(negedge clk);
      end
      check("big_done", done2, 1);
      check("big_cycles", cyc, RUN_B);
      check("big_fail_count", fail_count2, 255);
      check("big_pass", pass2, 0);
      check("big_fail_addr", fail_addr2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- Built-in self-test initiator that drives the write port and read port of the team's synchronous dual-port SRAM.
- Consumes the SRAM read data and checks it against an expected pattern.
- Runs a two-pass write/read-compare sequence over every address: a true pattern, then its inverse.
- Reports pass/fail, the first failing address and a saturating error count; sits between test/boot control logic and the SRAM instance.

Parameters:
- data_width, 8, width of SRAM data word.
- RAM_size, 16, number of SRAM words tested (addresses 0..RAM_size-1).
- address_width, 4, width of SRAM address ports.
- pattern, 8'hA5, base data pattern (data_width bits).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins a test run when sampled in IDLE or DONE.
- data_out_port  input  data_width  SRAM read data; valid the cycle after rd_en is sampled.
- wr_en  output  1  SRAM write enable.
- wr_addr  output  address_width  SRAM write address.
- data_in  output  data_width  SRAM write data.
- rd_en  output  1  SRAM read enable.
- rd_addr  output  address_width  SRAM read address.
- busy  output  1  high while a test run is in progress.
- done  output  1  high in DONE; result outputs are valid.
- pass  output  1  1 = no miscompare in the last run; valid only when done=1.
- fail_addr  output  address_width  address of the first miscompare; 0 if none.
- fail_count  output  8  miscompare count, saturating at 255.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high (ports clk, rst).
- Outputs: all registered. Reset value of every output is 0; the state machine goes to IDLE.
- Expected data: expected(p,a) = pattern XOR a, with a zero-extended or truncated to data_width. Pass p=1 uses the bitwise inverse of that value.
- States: IDLE, WRITE, READ, FLUSH, DONE; pass bit p and address counter a.
- IDLE/DONE: a start sampled here clears p, a, fail_addr and fail_count, and sets pass=1. Next state is WRITE; busy=1 and done=0 from that edge.
- WRITE: wr_en=1, wr_addr=a, data_in=expected(p,a), one address per cycle from 0 to RAM_size-1. After the last address, go to READ with a=0.
- READ: rd_en=1, rd_addr=a, one address per cycle. Expected value and address are delayed one cycle, together with a compare-valid flag, to align with SRAM read latency. After the last address, go to FLUSH.
- FLUSH: rd_en=0; the final pipelined compare executes. Then, if p=0, set p=1 and go to WRITE; otherwise go to DONE.
- Compare: on compare-valid with data_out_port != expected:
  - pass <= 0;
  - fail_count increments, saturating at 255;
  - fail_addr is captured only on the first miscompare of the run.
- DONE: busy=0, done=1; pass, fail_addr and fail_count are held until the next start.
- Write and read are never asserted in the same cycle, so no same-address collision can occur.
- Run length: RAM_size=16 gives 2*(2*16+1)=66 cycles from the start edge to done.
- start while busy=1: ignored, with no effect on state or results.
- rst mid-run: all outputs return to 0 on the next edge and the state machine goes to IDLE. The partial result is discarded and the SRAM contents are undefined to the test.
- Counters: the address counter wraps only under state-machine control and never exceeds RAM_size-1. RAM_size smaller than 2^address_width is supported.

Test Plan:
- Fault-free SRAM, start pulse at cycle 0 -> busy for 66 cycles, then done=1, pass=1, fail_count=0, fail_addr=0.
- Write-sequence check, pass 0 -> wr_addr 0,1,2,3 carry data_in A5,A4,A7,A6. Pass 1 addr 0 carries 5A.
- SRAM model forcing bit0 of addr 5 to 0, so pass-1 expected 5F reads 5E -> done with pass=0, fail_addr=5, fail_count=1.
- Corrupt all reads in both passes -> fail_count=32, fail_addr=0.
- Corrupt all reads with RAM_size=256 (address_width=8) -> fail_count saturates at 255.
- start pulsed again at cycle 10 of a run -> no restart; done still at cycle 66.
- rst asserted at cycle 20 -> next edge: all outputs 0, state IDLE. A new start then completes with pass=1 after 66 cycles.
- Second start while in DONE -> done drops and busy rises on the next edge. Results are cleared and the run repeats.
